// File: rtl/intdiv_pkg.sv
// ----------------------------------------------------------------------------
// intdiv_pkg
//   Shared types and helpers for the iterative restoring divider.
//   - intdiv_state_t : FSM encoding (IDLE, CALC, DONE)
//   - intdiv_seq_lat : number of CALC cycles for a normal divide
//   - intdiv_cnt_w   : width of the step counter for a given quotient width
// ----------------------------------------------------------------------------
package intdiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } intdiv_state_t;

   // Default quotient width and the matching step-counter width.
   localparam int INTDIV_LOGA_DEF  = 64;
   localparam int INTDIV_CNT_W_DEF = $clog2(INTDIV_LOGA_DEF + 1);

   // CALC cycles needed for a non-exceptional divide.
   function automatic int intdiv_seq_lat(input int loga, input int steps);
      return loga / steps;
   endfunction

   // The counter must be able to hold the value LOGA itself.
   function automatic int intdiv_cnt_w(input int loga);
      return $clog2(loga + 1);
   endfunction

endpackage

// File: rtl/intdiv_step.sv
// ----------------------------------------------------------------------------
// intdiv_step
//   One combinational restoring-division step.
//   Ports:
//     p      in  LOGB   partial remainder, always < d
//     nbit   in  1      next dividend bit (MSB first)
//     d      in  LOGB   divisor
//     p_next out LOGB   updated partial remainder
//     qbit   out 1      quotient bit produced by this step
// ----------------------------------------------------------------------------
module intdiv_step
   import intdiv_pkg::*;
#(
   parameter int LOGB = 64
) (
   input  logic [LOGB-1:0] p,
   input  logic            nbit,
   input  logic [LOGB-1:0] d,
   output logic [LOGB-1:0] p_next,
   output logic            qbit
);

   logic [LOGB:0] trial;
   logic [LOGB:0] diff;

   assign trial = {p, nbit};
   assign diff  = trial - {1'b0, d};

   // Because p < d, trial < 2*d: a successful subtraction leaves diff < d
   // (MSB clear), while a failed one wraps above 2^LOGB (MSB set). The MSB
   // is therefore exactly the borrow.
   assign qbit   = ~diff[LOGB];
   assign p_next = qbit ? diff[LOGB-1:0] : trial[LOGB-1:0];

endmodule

// File: rtl/intdiv_seq.sv
// ----------------------------------------------------------------------------
// intdiv_seq
//   Iterative restoring unsigned divider: N = Q*D + R, R < D.
//   STEPS restoring steps are chained per clock, so a normal divide spends
//   LOGA/STEPS cycles in CALC. Zero divisor and quotient overflow are detected
//   at accept time and go straight to DONE.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     in_valid   N/D offered          in_ready   divider idle, accepts N/D
//     N          dividend (LOGA+LOGB) D          divisor (LOGB)
//     out_valid  result held          out_ready  downstream takes result
//     Q          quotient (LOGA)      R          remainder (LOGB)
//     div0       D was zero           ovf        quotient exceeds LOGA bits
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. The result stays valid and unchanged until out_ready is seen;
//   Q/R/flags then keep their values, qualified only by out_valid.
// ----------------------------------------------------------------------------
module intdiv_seq
   import intdiv_pkg::*;
#(
   parameter int LOGA  = INTDIV_LOGA_DEF,
   parameter int LOGB  = 64,
   parameter int STEPS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [LOGA+LOGB-1:0] N,
   input  logic [LOGB-1:0]      D,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [LOGA-1:0]      Q,
   output logic [LOGB-1:0]      R,
   output logic                 div0,
   output logic                 ovf
);

   localparam int CNT_W = intdiv_cnt_w(LOGA);
   localparam int LAT   = intdiv_seq_lat(LOGA, STEPS);

   if (STEPS < 1 || STEPS > 4 || (LOGA % STEPS) != 0 || LAT * STEPS != LOGA
       || LOGA < 2) begin : g_bad_params
      $error("intdiv_seq: STEPS must be 1..4 and divide LOGA (LOGA >= 2)");
   end

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   intdiv_state_t   state;
   intdiv_state_t   state_next;

   logic [LOGB-1:0]  p_r;    // partial remainder
   logic [LOGA-1:0]  w_r;    // low dividend bits shifting out, quotient bits shifting in
   logic [LOGB-1:0]  d_r;    // latched divisor
   logic [CNT_W-1:0] cnt;    // restoring steps completed

   // -------------------------------------------------------------------------
   // Accept-time classification
   // -------------------------------------------------------------------------
   logic [LOGB-1:0] n_hi;
   logic            is_div0;
   logic            is_ovf;
   logic            calc_last;

   assign n_hi      = N[LOGA+LOGB-1:LOGA];
   assign is_div0   = (D == '0);
   // Upper dividend half >= D means the quotient needs more than LOGA bits.
   assign is_ovf    = !is_div0 && (n_hi >= D);
   assign calc_last = (cnt == CNT_W'(LOGA - STEPS));

   // -------------------------------------------------------------------------
   // Step chain: STEPS restoring steps per cycle, MSB first
   // -------------------------------------------------------------------------
   logic [LOGB-1:0] p_chain [STEPS+1];
   logic [LOGA-1:0] w_chain [STEPS+1];
   logic            q_chain [STEPS];

   assign p_chain[0] = p_r;
   assign w_chain[0] = w_r;

   for (genvar i = 0; i < STEPS; i++) begin : g_step
      intdiv_step #(
         .LOGB (LOGB)
      ) u_step (
         .p      (p_chain[i]),
         .nbit   (w_chain[i][LOGA-1]),
         .d      (d_r),
         .p_next (p_chain[i+1]),
         .qbit   (q_chain[i])
      );
      assign w_chain[i+1] = {w_chain[i][LOGA-2:0], q_chain[i]};
   end

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_next = (is_div0 || is_ovf) ? DONE : CALC;
            end
         end
         CALC: begin
            if (calc_last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: outputs
   // -------------------------------------------------------------------------
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE:    in_ready  = 1'b1;
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_r  <= '0;
         w_r  <= '0;
         d_r  <= '0;
         cnt  <= '0;
         Q    <= '0;
         R    <= '0;
         div0 <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  d_r <= D;
                  if (is_div0) begin
                     Q    <= '1;
                     R    <= N[LOGB-1:0];
                     div0 <= 1'b1;
                     ovf  <= 1'b0;
                  end else if (is_ovf) begin
                     Q    <= '1;
                     R    <= N[LOGB-1:0];
                     div0 <= 1'b0;
                     ovf  <= 1'b1;
                  end else begin
                     p_r <= n_hi;
                     w_r <= N[LOGA-1:0];
                     cnt <= '0;
                  end
               end
            end
            CALC: begin
               p_r <= p_chain[STEPS];
               w_r <= w_chain[STEPS];
               cnt <= cnt + CNT_W'(STEPS);
               if (calc_last) begin
                  Q    <= w_chain[STEPS];
                  R    <= p_chain[STEPS];
                  div0 <= 1'b0;
                  ovf  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_intdiv_seq.sv
// ----------------------------------------------------------------------------
// tb_intdiv_seq
//   Three dividers (STEPS = 1, 2, 4; LOGA = LOGB = 8) share stimulus. Each
//   operation is checked on all three for Q, R, flags and latency (rising
//   edges after the accepting edge until out_valid is seen).
// ----------------------------------------------------------------------------
module tb_intdiv_seq;

   localparam int LA = 8;
   localparam int LB = 8;

   typedef struct {
      logic [15:0] n;
      logic [7:0]  d;
      logic [7:0]  q;
      logic [7:0]  r;
      logic        dz;
      logic        ov;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        in_valid  = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] n_in      = '0;
   logic [7:0]  d_in      = '0;

   logic       in_ready_o  [3];
   logic       out_valid_o [3];
   logic [7:0] q_o         [3];
   logic [7:0] r_o         [3];
   logic       div0_o      [3];
   logic       ovf_o       [3];

   int steps_of [3] = '{1, 2, 4};

   intdiv_seq #(.LOGA(LA), .LOGB(LB), .STEPS(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o[0]),
      .N(n_in), .D(d_in), .out_valid(out_valid_o[0]), .out_ready(out_ready),
      .Q(q_o[0]), .R(r_o[0]), .div0(div0_o[0]), .ovf(ovf_o[0]));

   intdiv_seq #(.LOGA(LA), .LOGB(LB), .STEPS(2)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o[1]),
      .N(n_in), .D(d_in), .out_valid(out_valid_o[1]), .out_ready(out_ready),
      .Q(q_o[1]), .R(r_o[1]), .div0(div0_o[1]), .ovf(ovf_o[1]));

   intdiv_seq #(.LOGA(LA), .LOGB(LB), .STEPS(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o[2]),
      .N(n_in), .D(d_in), .out_valid(out_valid_o[2]), .out_ready(out_ready),
      .Q(q_o[2]), .R(r_o[2]), .div0(div0_o[2]), .ovf(ovf_o[2]));

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model for random stimulus.
   task automatic ref_div(input logic [15:0] n, input logic [7:0] d,
                          output logic [7:0] q, output logic [7:0] r,
                          output logic dz, output logic ov);
      int ni;
      int di;
      ni = int'(n);
      di = int'(d);
      dz = 1'b0;
      ov = 1'b0;
      if (di == 0) begin
         dz = 1'b1; q = 8'hFF; r = n[7:0];
      end else if (int'(n[15:8]) >= di) begin
         ov = 1'b1; q = 8'hFF; r = n[7:0];
      end else begin
         q = 8'(ni / di);
         r = 8'(ni % di);
      end
   endtask

   // ---------------- driver ----------------
   task automatic wait_idle();
      int k;
      k = 0;
      while (!(in_ready_o[0] && in_ready_o[1] && in_ready_o[2]) && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 50) begin
         n_checks++;
         n_errors++;
         $display("FAIL idle_timeout: in_ready not seen within 50 cycles");
      end
   endtask

   // Accept one operation on all three dividers, check results and latency,
   // then optionally complete the output handshake.
   task automatic run_op(input logic [15:0] n, input logic [7:0] d,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic edz, input logic eov, input bit do_hs);
      bit seen [3];
      int lat  [3];
      int k;
      wait_idle();
      n_in      = n;
      d_in      = d;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         seen[i] = 1'b0;
         lat[i]  = 99;
      end
      k = 0;
      while (1) begin
         for (int i = 0; i < 3; i++) begin
            if (!seen[i] && out_valid_o[i]) begin
               seen[i] = 1'b1;
               lat[i]  = k;
            end
         end
         if ((seen[0] && seen[1] && seen[2]) || k >= 40) break;
         @(posedge clk); #1;
         k++;
      end
      for (int i = 0; i < 3; i++) begin
         int exp_lat;
         exp_lat = (edz || eov) ? 0 : LA / steps_of[i];
         chk($sformatf("lat s%0d n=%h d=%h", steps_of[i], n, d), lat[i], exp_lat);
         chk($sformatf("q s%0d n=%h d=%h", steps_of[i], n, d), {24'd0, q_o[i]}, {24'd0, eq});
         chk($sformatf("r s%0d n=%h d=%h", steps_of[i], n, d), {24'd0, r_o[i]}, {24'd0, er});
         chk($sformatf("div0 s%0d n=%h d=%h", steps_of[i], n, d), {31'd0, div0_o[i]}, {31'd0, edz});
         chk($sformatf("ovf s%0d n=%h d=%h", steps_of[i], n, d), {31'd0, ovf_o[i]}, {31'd0, eov});
      end
      if (do_hs) begin
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         chk("out_valid_drop", {31'd0, out_valid_o[0]}, 32'd0);
         chk("in_ready_after_hs", {31'd0, in_ready_o[0]}, 32'd1);
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   vec_t vecs [13];

   initial begin
      logic [7:0]  rq, rr, rd, hi;
      logic        rz, ro;
      logic [15:0] rn;

      vecs[0]  = '{16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0};
      vecs[1]  = '{16'h00FF, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0};
      vecs[2]  = '{16'h5600, 8'h56, 8'hFF, 8'h00, 1'b0, 1'b1};
      vecs[3]  = '{16'h55FF, 8'h56, 8'hFF, 8'h55, 1'b0, 1'b0};
      vecs[4]  = '{16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0};
      vecs[5]  = '{16'h0000, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0};
      vecs[6]  = '{16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0};
      vecs[7]  = '{16'h0100, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b1};
      vecs[8]  = '{16'h1000, 8'hFF, 8'h10, 8'h10, 1'b0, 1'b0};
      vecs[9]  = '{16'h0007, 8'h03, 8'h02, 8'h01, 1'b0, 1'b0};
      vecs[10] = '{16'h3000, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0};
      vecs[11] = '{16'h8000, 8'h80, 8'hFF, 8'h00, 1'b0, 1'b1};
      vecs[12] = '{16'h7FFF, 8'h80, 8'hFF, 8'h7F, 1'b0, 1'b0};

      // Reset values while rst is held.
      #12;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst in_ready s%0d", steps_of[i]), {31'd0, in_ready_o[i]}, 32'd1);
         chk($sformatf("rst out_valid s%0d", steps_of[i]), {31'd0, out_valid_o[i]}, 32'd0);
      end
      chk("rst q", {24'd0, q_o[0]}, 32'd0);
      chk("rst r", {24'd0, r_o[0]}, 32'd0);
      chk("rst div0", {31'd0, div0_o[0]}, 32'd0);
      chk("rst ovf", {31'd0, ovf_o[0]}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed table.
      for (int v = 0; v < 13; v++) begin
         run_op(vecs[v].n, vecs[v].d, vecs[v].q, vecs[v].r, vecs[v].dz, vecs[v].ov, 1'b1);
      end

      // Backpressure: result held, new requests ignored while DONE.
      run_op(16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 5; c++) begin
         in_valid = (c % 2 == 0);
         n_in     = 16'h00FF;
         d_in     = 8'h00;
         @(posedge clk); #1;
         chk($sformatf("hold out_valid c%0d", c), {31'd0, out_valid_o[0]}, 32'd1);
         chk($sformatf("hold in_ready c%0d", c), {31'd0, in_ready_o[0]}, 32'd0);
         chk($sformatf("hold q c%0d", c), {24'd0, q_o[0]}, 32'h36);
         chk($sformatf("hold r c%0d", c), {24'd0, r_o[0]}, 32'h10);
         chk($sformatf("hold div0 c%0d", c), {31'd0, div0_o[0]}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("release in_ready", {31'd0, in_ready_o[0]}, 32'd1);
      chk("release out_valid", {31'd0, out_valid_o[0]}, 32'd0);
      chk("release q kept", {24'd0, q_o[0]}, 32'h36);
      chk("release r kept", {24'd0, r_o[0]}, 32'h10);

      // Reset in the third CALC cycle aborts the operation.
      wait_idle();
      n_in     = 16'h1234;
      d_in     = 8'h56;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("calc busy in_ready", {31'd0, in_ready_o[0]}, 32'd0);
      rst = 1'b1;
      #1;
      chk("abort in_ready", {31'd0, in_ready_o[0]}, 32'd1);
      chk("abort out_valid", {31'd0, out_valid_o[0]}, 32'd0);
      chk("abort q", {24'd0, q_o[0]}, 32'd0);
      chk("abort r", {24'd0, r_o[0]}, 32'd0);
      chk("abort div0", {31'd0, div0_o[0]}, 32'd0);
      chk("abort ovf", {31'd0, ovf_o[0]}, 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      @(posedge clk); #1;
      run_op(16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0, 1'b1);

      // Random operations against the reference model.
      for (int t = 0; t < 5000; t++) begin
         case ($urandom_range(0, 9))
            0:       rd = 8'h01;
            1:       rd = 8'hFF;
            2:       rd = 8'h00;
            default: rd = 8'($urandom_range(1, 255));
         endcase
         if (rd != 8'h00 && $urandom_range(0, 3) != 0)
            hi = 8'($urandom_range(0, int'(rd) - 1));
         else
            hi = 8'($urandom_range(0, 255));
         rn = {hi, 8'($urandom_range(0, 255))};
         ref_div(rn, rd, rq, rr, rz, ro);
         run_op(rn, rd, rq, rr, rz, ro, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
